// File: rtl/tdm_demux1_4.sv
// tdm_demux1_4: receive end of the 4:1 slot multiplexer link.
// This module splits a serial sample stream into four lanes, one per slot.
// Samples for slots 0..2 are first held in staging registers.
// All four lanes are then loaded together on the slot-3 sample,
// so y0..y3 always belong to one complete frame.
// The sync error checks keep the receiver aligned to frame_sync.
module tdm_demux1_4 #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q;
  logic [1:0]       slot_q;
  logic [WIDTH-1:0] s0_q, s1_q, s2_q;
  logic [WIDTH-1:0] y0_q, y1_q, y2_q, y3_q;
  logic             frameValid_q;
  logic             syncErr_q;
  logic [ERR_W-1:0] errCount_q;
  logic [ERR_W-1:0] errCount_d;

  // Saturating increment of the error counter; it sticks at all-ones
  always_comb begin
    errCount_d = errCount_q;
    if (errCount_q != {ERR_W{1'b1}}) begin
      errCount_d = errCount_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  // Alignment FSM, staging registers and registered lane outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      slot_q       <= 2'd0;
      s0_q         <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      y0_q         <= '0;
      y1_q         <= '0;
      y2_q         <= '0;
      y3_q         <= '0;
      frameValid_q <= 1'b0;
      syncErr_q    <= 1'b0;
      errCount_q   <= '0;
    end else begin
      frameValid_q <= 1'b0;
      syncErr_q    <= 1'b0;
      if (din_valid) begin
        case (state_q)
          HUNT: begin
            if (frame_sync) begin
              s0_q    <= din;
              slot_q  <= 2'd1;
              state_q <= LOCKED;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              // A sync in the middle of a frame discards the partial frame,
              // then the receiver realigns on this sample
              if (slot_q != 2'd0) begin
                syncErr_q  <= 1'b1;
                errCount_q <= errCount_d;
              end
              s0_q   <= din;
              slot_q <= 2'd1;
            end else begin
              case (slot_q)
                2'd0: begin
                  syncErr_q  <= 1'b1;
                  errCount_q <= errCount_d;
                  slot_q     <= 2'd0;
                  state_q    <= HUNT;
                end
                2'd1: begin
                  s1_q   <= din;
                  slot_q <= 2'd2;
                end
                2'd2: begin
                  s2_q   <= din;
                  slot_q <= 2'd3;
                end
                default: begin
                  y0_q         <= s0_q;
                  y1_q         <= s1_q;
                  y2_q         <= s2_q;
                  y3_q         <= din;
                  frameValid_q <= 1'b1;
                  slot_q       <= 2'd0;
                end
              endcase
            end
          end
          default: begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
          end
        endcase
      end
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign frame_valid = frameValid_q;
  assign slot        = slot_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = syncErr_q;
  assign err_count   = errCount_q;

endmodule

// File: tb/tb_tdm_demux1_4.sv
// tb_tdm_demux1_4: directed scenarios for the 1-to-4 TDM demultiplexer.
// The main instance uses the default widths.
// A second instance with ERR_W=2 exercises err_count saturation.
module tb_tdm_demux1_4;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] y0, y1, y2, y3;
  logic       frame_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;
  logic [7:0] err_count;

  logic       rst2;
  logic [7:0] din2;
  logic       din_valid2;
  logic       frame_sync2;
  logic [7:0] y0b, y1b, y2b, y3b;
  logic       frame_valid2;
  logic [1:0] slot2;
  logic       locked2;
  logic       sync_err2;
  logic [1:0] err_count2;

  int checks;
  int failures;

  tdm_demux1_4 #(.WIDTH(8), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .frame_valid(frame_valid), .slot(slot),
    .locked(locked), .sync_err(sync_err), .err_count(err_count)
  );

  tdm_demux1_4 #(.WIDTH(8), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst2), .din(din2), .din_valid(din_valid2), .frame_sync(frame_sync2),
    .y0(y0b), .y1(y1b), .y2(y2b), .y3(y3b), .frame_valid(frame_valid2), .slot(slot2),
    .locked(locked2), .sync_err(sync_err2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle on the main instance and settle just after the edge
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on the saturation instance
  task automatic step2(input logic v, input logic s, input logic [7:0] d);
    din_valid2  = v;
    frame_sync2 = s;
    din2        = d;
    @(posedge clk);
    #1;
  endtask

  // Reset values, followed by one continuous frame
  task automatic test_reset;
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if ({y0, y1, y2, y3, frame_valid, slot, locked, sync_err, err_count} !== 45'd0) begin
      $display("[TB] FAIL reset_state got y=%h%h%h%h fv=%b slot=%0d lk=%b se=%b ec=%0d want all 0",
               y0, y1, y2, y3, frame_valid, slot, locked, sync_err, err_count);
      failures++;
    end
    rst = 1'b0;
    step(1'b1, 1'b1, 8'h11);
    checks++;
    if (locked !== 1'b1 || slot !== 2'd1) begin
      $display("[TB] FAIL lock_on_sync got lk=%b slot=%0d want 1/1", locked, slot);
      failures++;
    end
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    checks++;
    if (frame_valid !== 1'b0 || slot !== 2'd3) begin
      $display("[TB] FAIL pre_frame got fv=%b slot=%0d want 0/3", frame_valid, slot);
      failures++;
    end
    step(1'b1, 1'b0, 8'h44);
    checks++;
    if ({y0, y1, y2, y3} !== 32'h11223344 || frame_valid !== 1'b1 || locked !== 1'b1 ||
        err_count !== 8'd0 || slot !== 2'd0) begin
      $display("[TB] FAIL frame1 got y=%h%h%h%h fv=%b lk=%b ec=%0d slot=%0d want 11223344/1/1/0/0",
               y0, y1, y2, y3, frame_valid, locked, err_count, slot);
      failures++;
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (frame_valid !== 1'b0 || {y0, y1, y2, y3} !== 32'h11223344) begin
      $display("[TB] FAIL fv_pulse got fv=%b y=%h%h%h%h want 0/11223344",
               frame_valid, y0, y1, y2, y3);
      failures++;
    end
  endtask

  // Idle cycles between samples; lanes hold until the 4th valid sample
  task automatic test_gaps;
    logic [7:0] vals [4];
    vals = '{8'h61, 8'h62, 8'h63, 8'h64};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), vals[i]);
      if (i < 3) begin
        checks++;
        if (frame_valid !== 1'b0 || {y0, y1, y2, y3} !== 32'h11223344) begin
          $display("[TB] FAIL gap_sample%0d got fv=%b y=%h%h%h%h want 0/11223344",
                   i, frame_valid, y0, y1, y2, y3);
          failures++;
        end
      end
      step(1'b0, 1'b1, 8'hFF);
      step(1'b0, 1'b0, 8'hEE);
      checks++;
      if (frame_valid !== 1'b0 || slot !== 2'((i + 1) % 4)) begin
        $display("[TB] FAIL gap_idle%0d got fv=%b slot=%0d want 0/%0d",
                 i, frame_valid, slot, (i + 1) % 4);
        failures++;
      end
    end
    checks++;
    if ({y0, y1, y2, y3} !== 32'h61626364 || err_count !== 8'd0) begin
      $display("[TB] FAIL gap_frame got y=%h%h%h%h ec=%0d want 61626364/0",
               y0, y1, y2, y3, err_count);
      failures++;
    end
  endtask

  // Two frames with din_valid held high; frame_valid on every 4th sample
  task automatic test_back_to_back;
    logic [7:0] vals [8];
    vals = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h81, 8'h82, 8'h83, 8'h84};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i % 4 == 0), vals[i]);
      checks++;
      if (frame_valid !== ((i % 4) == 3)) begin
        $display("[TB] FAIL b2b_fv%0d got fv=%b want %b", i, frame_valid, (i % 4) == 3);
        failures++;
      end
      if (i == 3) begin
        checks++;
        if ({y0, y1, y2, y3} !== 32'h71727374) begin
          $display("[TB] FAIL b2b_frameA got y=%h%h%h%h want 71727374", y0, y1, y2, y3);
          failures++;
        end
      end
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if ({y0, y1, y2, y3} !== 32'h81828384 || sync_err !== 1'b0) begin
      $display("[TB] FAIL b2b_frameB got y=%h%h%h%h se=%b want 81828384/0",
               y0, y1, y2, y3, sync_err);
      failures++;
    end
  endtask

  // A sync arriving in slot 2 drops the A frame and realigns on B0
  task automatic test_early_sync;
    step(1'b1, 1'b1, 8'hA0);
    step(1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b1, 8'hB0);
    checks++;
    if (sync_err !== 1'b1 || err_count !== 8'd1 || slot !== 2'd1 || locked !== 1'b1 ||
        {y0, y1, y2, y3} !== 32'h81828384) begin
      $display("[TB] FAIL early_sync got se=%b ec=%0d slot=%0d lk=%b y=%h%h%h%h want 1/1/1/1/81828384",
               sync_err, err_count, slot, locked, y0, y1, y2, y3);
      failures++;
    end
    step(1'b1, 1'b0, 8'hB1);
    checks++;
    if (sync_err !== 1'b0) begin
      $display("[TB] FAIL early_sync_pulse got se=%b want 0", sync_err);
      failures++;
    end
    step(1'b1, 1'b0, 8'hB2);
    step(1'b1, 1'b0, 8'hB3);
    checks++;
    if ({y0, y1, y2, y3} !== 32'hB0B1B2B3 || frame_valid !== 1'b1 || err_count !== 8'd1) begin
      $display("[TB] FAIL early_sync_frame got y=%h%h%h%h fv=%b ec=%0d want B0B1B2B3/1/1",
               y0, y1, y2, y3, frame_valid, err_count);
      failures++;
    end
  endtask

  // A missing sync at slot 0 drops back to HUNT until the next sync
  task automatic test_missing_sync;
    step(1'b1, 1'b0, 8'h55);
    checks++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd2 || slot !== 2'd0 ||
        {y0, y1, y2, y3} !== 32'hB0B1B2B3) begin
      $display("[TB] FAIL missing_sync got se=%b lk=%b ec=%0d slot=%0d y=%h%h%h%h want 1/0/2/0/B0B1B2B3",
               sync_err, locked, err_count, slot, y0, y1, y2, y3);
      failures++;
    end
    step(1'b1, 1'b0, 8'h66);
    step(1'b1, 1'b0, 8'h77);
    checks++;
    if (sync_err !== 1'b0 || locked !== 1'b0 || err_count !== 8'd2 || slot !== 2'd0) begin
      $display("[TB] FAIL hunt_ignore got se=%b lk=%b ec=%0d slot=%0d want 0/0/2/0",
               sync_err, locked, err_count, slot);
      failures++;
    end
    step(1'b1, 1'b1, 8'hC0);
    step(1'b1, 1'b0, 8'hC1);
    step(1'b1, 1'b0, 8'hC2);
    step(1'b1, 1'b0, 8'hC3);
    checks++;
    if ({y0, y1, y2, y3} !== 32'hC0C1C2C3 || frame_valid !== 1'b1 || locked !== 1'b1) begin
      $display("[TB] FAIL relock_frame got y=%h%h%h%h fv=%b lk=%b want C0C1C2C3/1/1",
               y0, y1, y2, y3, frame_valid, locked);
      failures++;
    end
  endtask

  // Reset after two samples wins over a valid sync sample
  task automatic test_reset_mid_frame;
    step(1'b1, 1'b1, 8'hD0);
    step(1'b1, 1'b0, 8'hD1);
    rst = 1'b1;
    step(1'b1, 1'b1, 8'hEE);
    rst = 1'b0;
    checks++;
    if ({y0, y1, y2, y3} !== 32'h0 || locked !== 1'b0 || slot !== 2'd0 ||
        err_count !== 8'd0 || frame_valid !== 1'b0) begin
      $display("[TB] FAIL reset_mid got y=%h%h%h%h lk=%b slot=%0d ec=%0d fv=%b want 0/0/0/0/0",
               y0, y1, y2, y3, locked, slot, err_count, frame_valid);
      failures++;
    end
    step(1'b1, 1'b1, 8'hE0);
    step(1'b1, 1'b0, 8'hE1);
    step(1'b1, 1'b0, 8'hE2);
    step(1'b1, 1'b0, 8'hE3);
    checks++;
    if ({y0, y1, y2, y3} !== 32'hE0E1E2E3 || frame_valid !== 1'b1) begin
      $display("[TB] FAIL post_reset_frame got y=%h%h%h%h fv=%b want E0E1E2E3/1",
               y0, y1, y2, y3, frame_valid);
      failures++;
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  // Five early syncs on the ERR_W=2 instance; the count sticks at 3
  task automatic test_err_saturation;
    int expCount;
    rst2 = 1'b1;
    step2(1'b0, 1'b0, 8'h00);
    rst2 = 1'b0;
    step2(1'b1, 1'b1, 8'hF0);
    for (int i = 1; i <= 5; i++) begin
      step2(1'b1, 1'b1, 8'(8'hF0 + i));
      expCount = (i > 3) ? 3 : i;
      checks++;
      if (sync_err2 !== 1'b1 || err_count2 !== 2'(expCount) || slot2 !== 2'd1) begin
        $display("[TB] FAIL sat_err%0d got se=%b ec=%0d slot=%0d want 1/%0d/1",
                 i, sync_err2, err_count2, slot2, expCount);
        failures++;
      end
    end
    step2(1'b0, 1'b0, 8'h00);
    checks++;
    if (sync_err2 !== 1'b0 || err_count2 !== 2'd3 || locked2 !== 1'b1) begin
      $display("[TB] FAIL sat_hold got se=%b ec=%0d lk=%b want 0/3/1",
               sync_err2, err_count2, locked2);
      failures++;
    end
  endtask

  // Scenario sequence; the second instance stays in reset until its turn
  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    din         = 8'h00;
    din_valid   = 1'b0;
    frame_sync  = 1'b0;
    rst2        = 1'b1;
    din2        = 8'h00;
    din_valid2  = 1'b0;
    frame_sync2 = 1'b0;
    #1;
    test_reset;
    test_gaps;
    test_back_to_back;
    test_early_sync;
    test_missing_sync;
    test_reset_mid_frame;
    test_err_saturation;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
